// File: rtl/fmap_pingpong_bank.sv
// Ping-pong feature-map buffer: writer fills one half while the reader replays the other cfg_passes times.
// Read latency 1 cycle, 1 word/cycle; wr_ready drops while the target half is full, rd_data holds under !rd_ready.
module fmap_pingpong_bank #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 8,
  parameter int DEPTH    = 12321,
  parameter int ADDR_W   = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [CHANNELS*DATA_W-1:0] wr_data,
  output logic                       wr_map_done,
  input  logic [7:0]                 cfg_passes,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [CHANNELS*DATA_W-1:0] rd_data,
  output logic                       rd_last,
  output logic                       rd_map_last,
  output logic [1:0]                 half_full
);

  localparam int W = CHANNELS * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} rd_state_t;

  logic [W-1:0]      mem [2][DEPTH];
  logic              wr_half;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_half;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        passes_left;
  rd_state_t         state;

  logic       wr_fire;
  logic       wr_at_last;
  logic       rd_issue;
  logic       rd_at_last;
  logic       rd_release;
  logic [1:0] half_full_nxt;

  assign wr_ready   = !half_full[wr_half];
  assign wr_fire    = wr_valid && wr_ready;
  assign wr_at_last = (wr_addr == LAST_ADDR);

  assign rd_issue   = (state == STREAM) && (!rd_valid || rd_ready);
  assign rd_at_last = (rd_addr == LAST_ADDR);
  assign rd_release = (state == DRAIN) && rd_valid && rd_ready && rd_map_last;

  // Writer and reader always own different halves, so set and clear never collide.
  always_comb begin
    half_full_nxt = half_full;
    if (wr_fire && wr_at_last)
      half_full_nxt[wr_half] = 1'b1;
    if (rd_release)
      half_full_nxt[rd_half] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_half][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_issue)
      rd_data <= mem[rd_half][rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_half     <= 1'b0;
      wr_addr     <= '0;
      half_full   <= 2'b00;
      wr_map_done <= 1'b0;
    end else begin
      half_full   <= half_full_nxt;
      wr_map_done <= wr_fire && wr_at_last;
      if (wr_fire) begin
        if (wr_at_last) begin
          wr_addr <= '0;
          wr_half <= ~wr_half;
        end else begin
          wr_addr <= wr_addr + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rd_half     <= 1'b0;
      rd_addr     <= '0;
      passes_left <= 8'd0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      rd_map_last <= 1'b0;
    end else begin
      if (rd_issue) begin
        rd_valid    <= 1'b1;
        rd_last     <= rd_at_last;
        rd_map_last <= rd_at_last && (passes_left == 8'd1);
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (half_full[rd_half]) begin
            passes_left <= (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
            rd_addr     <= '0;
            state       <= STREAM;
          end
        end
        STREAM: begin
          if (rd_issue) begin
            if (rd_at_last) begin
              rd_addr     <= '0;
              passes_left <= passes_left - 8'd1;
              if (passes_left == 8'd1)
                state <= DRAIN;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (rd_release) begin
            rd_half <= ~rd_half;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_pingpong_bank.sv
// Directed bench for fmap_pingpong_bank with DEPTH=4, CHANNELS=2, DATA_W=16.
module tb_fmap_pingpong_bank;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int DP = 4;
  localparam int AW = 2;

  logic            clk;
  logic            rst;
  logic            wr_valid;
  logic            wr_ready;
  logic [CH*DW-1:0] wr_data;
  logic            wr_map_done;
  logic [7:0]      cfg_passes;
  logic            rd_valid;
  logic            rd_ready;
  logic [CH*DW-1:0] rd_data;
  logic            rd_last;
  logic            rd_map_last;
  logic [1:0]      half_full;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fmap_pingpong_bank #(.DATA_W(DW), .CHANNELS(CH), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_map_done(wr_map_done),
    .cfg_passes(cfg_passes),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .rd_map_last(rd_map_last), .half_full(half_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Lane 0 carries base+k+1, lane 1 the same value plus 0x100.
  function automatic logic [31:0] word(input logic [15:0] base, input int k);
    logic [15:0] l0;
    l0 = base + 16'(k + 1);
    return {l0 + 16'h0100, l0};
  endfunction

  task automatic write_words(input logic [15:0] base, input int start, input int stop);
    for (int k = start; k < stop; k++) begin
      int guard;
      guard    = 0;
      wr_valid = 1'b1;
      wr_data  = word(base, k);
      while (!wr_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      chk("wr_wait", guard < 50, 1'b1);
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  // Consumes stream indices start..stop-1 of a map read 'total' words long; caller holds rd_ready high.
  task automatic expect_stream(input int start, input int stop, input int total,
                               input logic [15:0] base, output int first_c, output int last_c);
    first_c = 0;
    last_c  = 0;
    for (int i = start; i < stop; i++) begin
      int guard;
      guard = 0;
      while (!(rd_valid === 1'b1 && rd_ready) && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      chk("rd_wait", guard < 50, 1'b1);
      if (guard >= 50) return;
      chk("rd_data", rd_data, word(base, i % 4));
      chk("rd_last", rd_last, (i % 4) == 3);
      chk("rd_map_last", rd_map_last, i == total - 1);
      if (i == start) first_c = cyc;
      last_c = cyc;
      @(negedge clk);
    end
  endtask

  int fc, lc;

  initial begin
    rst        = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    cfg_passes = 8'd1;
    rd_ready   = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_half_full", half_full, 2'b00);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_map_done", wr_map_done, 1'b0);
    chk("rst_rd_last", rd_last, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Single pass into half 0, consumed back-to-back.
    write_words(16'h0000, 0, 4);
    chk("sp_map_done", wr_map_done, 1'b1);
    chk("sp_half_full", half_full, 2'b01);
    @(negedge clk);
    chk("sp_map_done_pulse", wr_map_done, 1'b0);
    expect_stream(0, 4, 4, 16'h0000, fc, lc);
    chk("sp_b2b_span", lc - fc, 3);
    chk("sp_released", half_full, 2'b00);
    chk("sp_rd_valid_low", rd_valid, 1'b0);

    // Three passes into half 1; cfg change after handoff must not matter.
    rd_ready   = 1'b0;
    cfg_passes = 8'd3;
    write_words(16'h0010, 0, 4);
    repeat (2) @(negedge clk);
    cfg_passes = 8'd7;
    rd_ready   = 1'b1;
    expect_stream(0, 12, 12, 16'h0010, fc, lc);
    chk("rp_released", half_full, 2'b00);
    repeat (3) @(negedge clk);
    chk("rp_no_extra", rd_valid, 1'b0);

    // cfg_passes=0 behaves as a single pass (half 0).
    cfg_passes = 8'd0;
    write_words(16'h0020, 0, 4);
    expect_stream(0, 4, 4, 16'h0020, fc, lc);
    repeat (3) @(negedge clk);
    chk("p0_no_extra", rd_valid, 1'b0);
    chk("p0_half_full", half_full, 2'b00);

    // Backpressure at word 2 (half 1).
    cfg_passes = 8'd1;
    write_words(16'h0000, 0, 4);
    expect_stream(0, 1, 4, 16'h0000, fc, lc);
    rd_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", rd_valid, 1'b1);
      chk("bp_hold_data", rd_data, 32'h0102_0002);
    end
    rd_ready = 1'b1;
    expect_stream(1, 4, 4, 16'h0000, fc, lc);

    // Both halves full, extra write refused.
    rd_ready = 1'b0;
    write_words(16'h0040, 0, 4);
    write_words(16'h0050, 0, 4);
    chk("pp_half_full", half_full, 2'b11);
    chk("pp_wr_ready", wr_ready, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    chk("pp_still_blocked", wr_ready, 1'b0);
    chk("pp_full_hold", half_full, 2'b11);
    chk("pp_no_map_done", wr_map_done, 1'b0);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    expect_stream(0, 4, 4, 16'h0040, fc, lc);
    chk("pp_wr_ready_back", wr_ready, 1'b1);
    chk("pp_half0_free", half_full, 2'b10);
    rd_ready = 1'b0;
    write_words(16'h0060, 0, 4);
    chk("pp_refill", half_full, 2'b11);
    rd_ready = 1'b1;
    expect_stream(0, 4, 4, 16'h0050, fc, lc);
    rd_ready = 1'b0;
    chk("pp_half1_free", half_full, 2'b01);

    // Final acceptance from half 0 coincides with last write into half 1.
    rd_ready = 1'b1;
    expect_stream(0, 3, 4, 16'h0060, fc, lc);
    rd_ready = 1'b0;
    chk("sim_pending_last", rd_map_last, 1'b1);
    chk("sim_pending_data", rd_data, word(16'h0060, 3));
    write_words(16'h0070, 0, 3);
    wr_valid = 1'b1;
    wr_data  = word(16'h0070, 3);
    rd_ready = 1'b1;
    chk("sim_pre", half_full, 2'b01);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("sim_swap", half_full, 2'b10);
    chk("sim_map_done", wr_map_done, 1'b1);
    chk("sim_rd_valid", rd_valid, 1'b0);
    @(negedge clk);
    chk("sim_map_done_once", wr_map_done, 1'b0);
    expect_stream(0, 4, 4, 16'h0070, fc, lc);
    chk("sim_all_free", half_full, 2'b00);

    // Asynchronous reset in the middle of pass 1.
    cfg_passes = 8'd2;
    write_words(16'h0080, 0, 4);
    expect_stream(0, 2, 8, 16'h0080, fc, lc);
    chk("mid_rd_valid_pre", rd_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("ar_rd_valid", rd_valid, 1'b0);
    chk("ar_half_full", half_full, 2'b00);
    chk("ar_rd_last", rd_last, 1'b0);
    chk("ar_rd_map_last", rd_map_last, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("ar_wr_ready", wr_ready, 1'b1);
    chk("ar_idle", rd_valid, 1'b0);
    cfg_passes = 8'd1;
    write_words(16'h0090, 0, 4);
    expect_stream(0, 4, 4, 16'h0090, fc, lc);
    chk("ar_end_free", half_full, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmap_pingpong_bank.md
Name: fmap_pingpong_bank

Overview:
- Parametrised multi-channel feature-map buffer between the squeeze and expand stages.
- Two ping-pong halves, each holding one full feature map: CHANNELS lanes × DEPTH words × DATA_W bits.
- Writer fills one half sequentially with addresses generated internally, while the reader streams the other half.
- The reader replays a completed map a configurable number of times (one pass per expand filter group) before releasing the half back to the writer.

Parameters:
- DATA_W, 16, bits per channel word
- CHANNELS, 8, parallel channel lanes
- DEPTH, 12321, words per channel per map (111×111)
- ADDR_W, 14, address counter width; must satisfy 2^ADDR_W ≥ DEPTH

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_valid  in  1  write word present
- wr_ready  out  1  buffer can accept a write word
- wr_data  in  CHANNELS*DATA_W  channel 0 in bits [DATA_W-1:0], ascending
- wr_map_done  out  1  one-cycle pulse when a half becomes full
- cfg_passes  in  8  read passes per map; sampled when a half is handed to the reader; 0 treated as 1
- rd_valid  out  1  rd_data holds a valid word
- rd_ready  in  1  consumer accepts rd_data
- rd_data  out  CHANNELS*DATA_W  read word, same packing as wr_data
- rd_last  out  1  qualifies rd_data as address DEPTH-1 of the current pass
- rd_map_last  out  1  rd_last of the final pass
- half_full  out  2  bit h = half h holds a complete, unreleased map

Behaviour:
- Reset: asserting rst clears immediately (async), mid-operation included:
  - wr_half=0, rd_half=0, both address counters 0, pass counter 0, half_full=00.
  - Outputs low: rd_valid, wr_map_done, rd_last, rd_map_last.
  - Memory contents are not cleared.
- Write side:
  - wr_ready = !half_full[wr_half].
  - Write fires on wr_valid && wr_ready: all lanes are written at address wr_addr of wr_half, then wr_addr increments.
  - At wr_addr == DEPTH-1 the write fires, then: wr_addr→0, half_full[wr_half]←1, wr_half toggles, wr_map_done pulses high for the next cycle.
  - wr_valid while !wr_ready is ignored; no state change, no data loss requirement on the source.
- Read side:
  - FSM with states IDLE, STREAM, DRAIN.
  - IDLE: when half_full[rd_half]=1, latch passes_left = max(cfg_passes,1), rd_addr=0, go to STREAM.
  - Read issue condition = state STREAM && (!rd_valid || rd_ready).
  - Memory read is synchronous. rd_data, rd_last and rd_map_last register at the edge after issue; rd_valid sets at that edge.
  - Read latency: 1 cycle. Throughput: 1 word/cycle with rd_ready held high.
  - If rd_valid && rd_ready and no issue that cycle, rd_valid clears at the next edge.
  - While rd_valid && !rd_ready: rd_data, rd_last and rd_map_last hold stable; no issue.
  - Issue at rd_addr == DEPTH-1:
    - rd_addr→0, passes_left decrements.
    - If passes_left was 1, go to DRAIN; the issued word carries rd_last=1 and rd_map_last=1.
    - Otherwise stay in STREAM; the word carries rd_last=1 only.
  - DRAIN: when the final word is accepted (rd_valid && rd_ready && rd_map_last):
    - half_full[rd_half]←0, rd_half toggles, go to IDLE.
    - The released half's wr_ready effect is visible the following cycle.
- Simultaneous events:
  - Write completing one half in the same cycle the reader releases the other: both half_full updates apply; the bits are independent.
  - Write and read never target the same half; this is guaranteed by the half_full gating.
- Boundary cases:
  - Both halves full: wr_ready=0 until the reader releases one.
  - Reader empty in IDLE: rd_valid=0.
  - cfg_passes changes mid-map: no effect until the next IDLE→STREAM handoff.
  - DEPTH=1: each issue is the last word of its pass.
- Widths: counters are ADDR_W bits and compare against DEPTH-1, so there is no wrap beyond DEPTH. passes_left is 8 bits.

Test Plan (DEPTH=4, CHANNELS=2, DATA_W=16 unless noted):
- Reset mid-stream: assert rst during STREAM pass 1 → rd_valid=0 and half_full=00 immediately; wr_ready=1 after release.
- Single pass, rd_ready=1: write words 0x0001..0x0004 (lane1 = lane0+0x100), cfg_passes=1 → wr_map_done pulses after 4th write; rd_data sequence 0x0101_0001..0x0104_0004 back-to-back, rd_last and rd_map_last on 4th word; half_full[0] clears the cycle after acceptance.
- Replay: cfg_passes=3 → 12 words are read, the 4-word pattern ×3; rd_last on words 4, 8, 12; rd_map_last only on word 12. cfg_passes=0 → exactly 1 pass.
- Backpressure: rd_ready low for 3 cycles at word 2 → rd_data holds 0x0102_0002 throughout; no skipped or duplicated words.
- Ping-pong full: write 8 words with rd_ready=0 → half_full=11, wr_ready=0, 9th write is not accepted. Release half 0 → wr_ready=1 one cycle later; next write lands in half 0; reader continues with half 1 data.
- Simultaneous: time the 4th write into half 1 to coincide with the final acceptance from half 0 → half_full goes 01→10 in one edge; wr_map_done pulses once.
